// File: rtl/instr_mem_loader.sv
// Byte-stream to 32-bit word loader for the instruction memory.
// Packs bytes little-endian, drives the word-addressed write port and keeps
// the core held until a complete image has been written.
module instr_mem_loader #(
   parameter int DEPTH  = 73,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   addr_reg, addr_next;
   logic [1:0]          lane_reg, lane_next;
   logic [31:0]         buf_reg, buf_next;
   logic                last_reg, last_next;
   logic [ADDR_W:0]     wc_reg, wc_next;
   logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
   logic [31:0]         wr_data_reg, wr_data_next;

   // Word buffer with the incoming byte dropped into the current lane.
   // Lanes above the current one are still zero from the last clear, so a
   // short final word is naturally zero-padded.
   logic [31:0]         merged;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign merged[8*gi +: 8] = (lane_reg == 2'(gi)) ? in_data : buf_reg[8*gi +: 8];
      end
   endgenerate

   // Status outputs decode straight from the state register, so in_ready
   // never depends on in_valid.
   assign in_ready   = (state_reg == LOAD);
   assign wr_en      = (state_reg == WRITE);
   assign cpu_hold   = (state_reg != DONE);
   assign done       = (state_reg == DONE);
   assign error      = (state_reg == ERROR);
   assign word_count = wc_reg;

   // The write port values are captured when the word completes, so they
   // are valid during WRITE and hold afterwards while wr_en is low.
   assign wr_addr    = wr_addr_reg;
   assign wr_data    = wr_data_reg;

   // Next-state and datapath update logic.
   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      lane_next    = lane_reg;
      buf_next     = buf_reg;
      last_next    = last_reg;
      wc_next      = wc_reg;
      wr_addr_next = wr_addr_reg;
      wr_data_next = wr_data_reg;

      case (state_reg)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_next = LOAD;
               addr_next  = '0;
               lane_next  = '0;
               buf_next   = '0;
               last_next  = 1'b0;
               wc_next    = '0;
            end
         end

         LOAD: begin
            if (in_valid) begin
               buf_next  = merged;
               lane_next = lane_reg + 2'd1;
               last_next = in_last;
               if (lane_reg == 2'd3 || in_last) begin
                  state_next   = WRITE;
                  wr_addr_next = addr_reg;
                  wr_data_next = merged;
               end
            end
         end

         WRITE: begin
            wc_next = wc_reg + 1'b1;
            if (last_reg) begin
               state_next = DONE;
            end else if (addr_reg == LAST_ADDR) begin
               // Memory is full but the stream has not ended: image too big.
               state_next = ERROR;
            end else begin
               state_next = LOAD;
               addr_next  = addr_reg + 1'b1;
               lane_next  = '0;
               buf_next   = '0;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any load in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         lane_reg    <= '0;
         buf_reg     <= '0;
         last_reg    <= 1'b0;
         wc_reg      <= '0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         lane_reg    <= lane_next;
         buf_reg     <= buf_next;
         last_reg    <= last_next;
         wc_reg      <= wc_next;
         wr_addr_reg <= wr_addr_next;
         wr_data_reg <= wr_data_next;
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a 4-word memory so that both
// the overflow and the exactly-full cases are reachable quickly.
module tb_instr_mem_loader;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        in_data;
   logic              in_last;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   int total = 0;
   int bad   = 0;

   // write log filled by the monitor below
   int                nw = 0;
   logic [ADDR_W-1:0] log_addr [16];
   logic [31:0]       log_data [16];

   instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // record every memory write, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (nw < 16) begin
            log_addr[nw] = wr_addr;
            log_data[nw] = wr_data;
         end
         nw = nw + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (n < 50) else begin
         bad++;
         $error("FAIL byte_accept_timeout observed=%0d expected=<50", n);
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_end();
      int n;
      n = 0;
      while (!(done === 1'b1 || error === 1'b1) && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (n < 100) else begin
         bad++;
         $error("FAIL end_timeout observed=%0d expected=<100", n);
      end
   endtask

   task automatic send_vec1(input bit gaps);
      logic [7:0] v [8];
      v = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00};
      for (int i = 0; i < 8; i++)
         send_byte(v[i], (i == 7), gaps ? int'($urandom_range(0, 3)) : 0);
   endtask

   initial begin
      int rdy_cnt;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      #12;
      // reset state
      check("rst_in_ready", 32'(in_ready), 32'h0);
      check("rst_wr_en", 32'(wr_en), 32'h0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'h1);
      check("rst_done", 32'(done), 32'h0);
      check("rst_error", 32'(error), 32'h0);
      check("rst_word_count", 32'(word_count), 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
      check("rst_wr_data", wr_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'h0);

      // two full words
      nw = 0;
      pulse_start();
      check("load_in_ready", 32'(in_ready), 32'h1);
      send_vec1(1'b0);
      wait_end();
      check("v1_nwrites", 32'(nw), 32'd2);
      check("v1_addr0", 32'(log_addr[0]), 32'd0);
      check("v1_data0", log_data[0], 32'h00000013);
      check("v1_addr1", 32'(log_addr[1]), 32'd1);
      check("v1_data1", log_data[1], 32'h00500093);
      check("v1_done", 32'(done), 32'h1);
      check("v1_cpu_hold", 32'(cpu_hold), 32'h0);
      check("v1_word_count", 32'(word_count), 32'd2);
      repeat (3) @(negedge clk);
      check("v1_hold_wr_en", 32'(wr_en), 32'h0);
      check("v1_hold_wr_addr", 32'(wr_addr), 32'd1);
      check("v1_hold_wr_data", wr_data, 32'h00500093);

      // restart from DONE, partial single word
      nw = 0;
      pulse_start();
      check("restart_cpu_hold", 32'(cpu_hold), 32'h1);
      check("restart_done", 32'(done), 32'h0);
      check("restart_word_count", 32'(word_count), 32'd0);
      send_byte(8'hAA, 1'b0, 0);
      send_byte(8'hBB, 1'b1, 0);
      wait_end();
      check("v2_nwrites", 32'(nw), 32'd1);
      check("v2_addr0", 32'(log_addr[0]), 32'd0);
      check("v2_data0", log_data[0], 32'h0000BBAA);
      check("v2_done", 32'(done), 32'h1);
      check("v2_word_count", 32'(word_count), 32'd1);

      // overflow: 16 bytes without last fill memory, then error
      nw = 0;
      pulse_start();
      for (int i = 0; i < 16; i++)
         send_byte(8'(i), 1'b0, 0);
      wait_end();
      check("ovf_nwrites", 32'(nw), 32'd4);
      check("ovf_addr3", 32'(log_addr[3]), 32'd3);
      check("ovf_data0", log_data[0], 32'h03020100);
      check("ovf_data3", log_data[3], 32'h0F0E0D0C);
      check("ovf_error", 32'(error), 32'h1);
      check("ovf_done", 32'(done), 32'h0);
      check("ovf_cpu_hold", 32'(cpu_hold), 32'h1);
      check("ovf_word_count", 32'(word_count), 32'd4);
      // 17th byte offered for a while: never accepted
      rdy_cnt = 0;
      in_valid = 1'b1; in_data = 8'h10;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready === 1'b1) rdy_cnt++;
      end
      in_valid = 1'b0;
      check("ovf_17th_ready", 32'(rdy_cnt), 32'd0);
      check("ovf_17th_nwrites", 32'(nw), 32'd4);
      check("ovf_17th_error", 32'(error), 32'h1);

      // exactly DEPTH words ending on last
      nw = 0;
      pulse_start();
      check("err_clear", 32'(error), 32'h0);
      for (int i = 0; i < 16; i++)
         send_byte(8'(8'h10 + i), (i == 15), 0);
      wait_end();
      check("full_nwrites", 32'(nw), 32'd4);
      check("full_data3", log_data[3], 32'h1F1E1D1C);
      check("full_done", 32'(done), 32'h1);
      check("full_error", 32'(error), 32'h0);
      check("full_word_count", 32'(word_count), 32'd4);

      // first vector again with random idle gaps
      nw = 0;
      pulse_start();
      send_vec1(1'b1);
      wait_end();
      check("gap_nwrites", 32'(nw), 32'd2);
      check("gap_data0", log_data[0], 32'h00000013);
      check("gap_data1", log_data[1], 32'h00500093);
      check("gap_word_count", 32'(word_count), 32'd2);

      // asynchronous reset mid-load
      pulse_start();
      for (int i = 0; i < 6; i++)
         send_byte(8'(8'h40 + i), 1'b0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'h0);
      check("arst_cpu_hold", 32'(cpu_hold), 32'h1);
      check("arst_word_count", 32'(word_count), 32'd0);
      check("arst_wr_addr", 32'(wr_addr), 32'd0);
      check("arst_wr_data", wr_data, 32'h0);
      check("arst_done", 32'(done), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      nw = 0;
      pulse_start();
      send_byte(8'h01, 1'b0, 0);
      send_byte(8'h02, 1'b0, 0);
      send_byte(8'h03, 1'b0, 0);
      send_byte(8'h04, 1'b1, 0);
      wait_end();
      check("rl_nwrites", 32'(nw), 32'd1);
      check("rl_addr0", 32'(log_addr[0]), 32'd0);
      check("rl_data0", log_data[0], 32'h04030201);
      check("rl_done", 32'(done), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
